// File: rtl/snake_sched_pkg.sv
// snake_sched_pkg: shared state encoding and score constants for the tick scheduler (SCHED_PAUSE_EN adds PAUSED)
package snake_sched_pkg;
  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    MOVE,
    EVAL,
    SPAWN,
    OVER
`ifdef SCHED_PAUSE_EN
    , PAUSED
`endif
  } state_t;
  localparam int SCORE_MAX = 9999;
  localparam int APPLE_INC_SLOW = 1;
  localparam int APPLE_INC_FAST = 2;
endpackage

// File: rtl/game_tick_scheduler_tick_divider.sv
// tick_divider: loadable down-counter with enable and freeze; tc flags the last cycle of a tick
module tick_divider #(
  parameter int W = 23
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic         freeze,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] cnt;
  // count down to zero and hold there until reloaded
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && !freeze && cnt != '0) cnt <= cnt - W'(1);
  assign tc = cnt == '0;
endmodule

// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: per-tick move/eval/spawn sequencer, game state and score; SCHED_PAUSE_EN enables pause
module game_tick_scheduler
  import snake_sched_pkg::*;
#(
  parameter int SLOW_DIV  = 8_000_000,
  parameter int FAST_DIV  = 4_000_000,
  parameter int MAX_RETRY = 8,
  parameter int SCORE_W   = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_pulse,
  input  logic               pause_pulse,
  input  logic               speed,
  input  logic               eval_valid,
  input  logic               collide,
  input  logic               ate_apple,
  input  logic               ate_drug,
  input  logic               spawn_ack,
  input  logic               spawn_conflict,
  output logic               gaming,
  output logic               game_over,
  output logic               move_stb,
  output logic               spawn_req,
  output logic [SCORE_W-1:0] score,
  output logic               score_zero,
  output logic               retry_exhausted
);
  localparam int MAXD = SLOW_DIV > FAST_DIV ? SLOW_DIV : FAST_DIV;
  localparam int CW = MAXD > 1 ? $clog2(MAXD) : 1;
  localparam int RW = MAX_RETRY > 1 ? $clog2(MAX_RETRY) : 1;
  localparam logic [SCORE_W+1:0] SMAX = (SCORE_W+2)'(SCORE_MAX);
  state_t state, nxt;
  logic tc, load, paused, ack_seen, last_try, start_go, req_gap;
  logic [RW-1:0] retry_cnt;
  logic [SCORE_W+1:0] sum, diff;
`ifdef SCHED_PAUSE_EN
  assign paused = state == PAUSED;
`else
  logic unused;
  assign paused = 1'b0;
  assign unused = pause_pulse;
`endif
  assign start_go = start_pulse && (state == IDLE || state == OVER);
  assign ack_seen = spawn_req && spawn_ack;
  assign last_try = retry_cnt == RW'(MAX_RETRY - 1);
  assign gaming = state != IDLE && state != OVER;
  assign game_over = state == OVER;
  assign move_stb = state == MOVE;
  assign spawn_req = state == SPAWN && !req_gap;
  assign load = nxt == WAIT_TICK && state inside {IDLE, EVAL, SPAWN, OVER};
  tick_divider #(.W(CW)) u_div (
    .clk      (clk),
    .rst      (rst),
    .en       (state == WAIT_TICK || paused),
    .load     (load),
    .freeze   (paused),
    .load_val (speed ? CW'(FAST_DIV - 1) : CW'(SLOW_DIV - 1)),
    .tc       (tc)
  );
  // next-state: one pass through the tick phases, collision ends the game
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = start_pulse ? WAIT_TICK : IDLE;
`ifdef SCHED_PAUSE_EN
      WAIT_TICK: nxt = pause_pulse ? PAUSED : tc ? MOVE : WAIT_TICK;
      PAUSED:    nxt = pause_pulse ? WAIT_TICK : PAUSED;
`else
      WAIT_TICK: nxt = tc ? MOVE : WAIT_TICK;
`endif
      MOVE:      nxt = EVAL;
      EVAL:      nxt = !eval_valid ? EVAL : collide ? OVER : ate_apple ? SPAWN : WAIT_TICK;
      SPAWN:     nxt = ack_seen && (!spawn_conflict || last_try) ? WAIT_TICK : SPAWN;
      OVER:      nxt = start_pulse ? WAIT_TICK : OVER;
      default:   nxt = IDLE;
    endcase
  end
  // apple and drug apply together, then clamp into 0..SCORE_MAX
  always_comb begin
    sum = {2'b00, score} + (ate_apple ? (speed ? (SCORE_W+2)'(APPLE_INC_FAST) : (SCORE_W+2)'(APPLE_INC_SLOW)) : '0);
    diff = (ate_drug && sum != '0) ? sum - (SCORE_W+2)'(1) : sum;
  end
  // state, score, spawn retry bookkeeping
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      score <= '0;
      score_zero <= 1'b0;
      retry_cnt <= '0;
      req_gap <= 1'b0;
      retry_exhausted <= 1'b0;
    end else begin
      state <= nxt;
      score_zero <= start_go;
      if (start_go) score <= '0;
      else if (state == EVAL && eval_valid && !collide) score <= diff > SMAX ? SMAX[SCORE_W-1:0] : diff[SCORE_W-1:0];
      if (nxt == SPAWN && state != SPAWN) retry_cnt <= '0;
      else if (ack_seen && spawn_conflict && !last_try) retry_cnt <= retry_cnt + RW'(1);
      req_gap <= ack_seen && spawn_conflict && nxt == SPAWN;
      if (start_go) retry_exhausted <= 1'b0;
      else if (ack_seen && spawn_conflict && last_try) retry_exhausted <= 1'b1;
    end
endmodule

// File: doc/game_tick_scheduler.md
# game_tick_scheduler

Central sequencer for the snake game datapath. Generates the per-tick phase order: move strobe, wait for the datapath's head evaluation, apple respawn handshake with conflict retry, and score update. It also owns the IDLE/PLAY/OVER game state and the score register that feeds the 7-segment display path. It replaces the free-running slow clocks (clk_12_5 / clk_25) with single-cycle enables in the clk domain.

## Interface
Parameters:
- SLOW_DIV, 8_000_000: clk cycles per tick in normal mode (12.5 Hz at 100 MHz).
- FAST_DIV, 4_000_000: clk cycles per tick in speed mode (25 Hz).
- MAX_RETRY, 8: spawn conflicts tolerated before forced accept.
- SCORE_W, 14: score width; score saturates at 9999.

Ports:
- clk, in, 1: system clock; the only clock. Reset is synchronous and active-high.
- rst, in, 1: synchronous, active-high reset.
- start_pulse, in, 1: one-pulse start/restart.
- pause_pulse, in, 1: one-pulse pause toggle (used only with SCHED_PAUSE_EN).
- speed, in, 1: 1 = fast (FAST_DIV, +2 per apple), 0 = slow (SLOW_DIV, +1 per apple).
- eval_valid, in, 1: datapath finished evaluating the new head position.
- collide, ate_apple, ate_drug, in, 1 each: evaluation results, qualified by eval_valid.
- spawn_ack, in, 1: apple generator produced a candidate.
- spawn_conflict, in, 1: candidate overlaps the snake; qualified by spawn_ack.
- gaming, out, 1: game in play.
- game_over, out, 1: game ended.
- move_stb, out, 1: one-cycle "advance snake" strobe.
- spawn_req, out, 1: request a new apple position.
- score, out, SCORE_W: binary score.
- score_zero, out, 1: clear pulse to timer/score consumers.
- retry_exhausted, out, 1: sticky flag; a spawn was force-accepted.

## Operation
- States: IDLE, WAIT_TICK, MOVE, EVAL, SPAWN, OVER, plus PAUSED when SCHED_PAUSE_EN is defined.
- IDLE: start_pulse → WAIT_TICK. That cycle score clears to 0 and score_zero pulses for one cycle.
- WAIT_TICK: tick counter counts 0..DIV-1. DIV is selected from speed, sampled on entry to WAIT_TICK; a speed change mid-count takes effect on the next tick. At DIV-1 → MOVE.
- MOVE: move_stb=1 for exactly one cycle → EVAL.
- EVAL: waits indefinitely for eval_valid.
  - collide=1 → OVER; collide has priority and ate_* are ignored.
  - Otherwise ate_apple adds 1 (slow) or 2 (fast), saturating at 9999.
  - Otherwise ate_drug subtracts 1, floored at 0.
  - If both are set, both apply in the same cycle: net +0 (slow) or +1 (fast).
  - ate_apple → SPAWN; else → WAIT_TICK.
- SPAWN: spawn_req is held high until the cycle spawn_ack=1, then dropped for at least one cycle.
  - ack with conflict=0 → WAIT_TICK.
  - ack with conflict=1 → retry_cnt+1 and re-request.
  - At the MAX_RETRY-th conflict, accept anyway, set retry_exhausted, → WAIT_TICK.
  - retry_cnt clears on SPAWN entry.
- OVER: game_over=1, gaming=0; score is held. start_pulse → WAIT_TICK with score clear and score_zero pulse, identical to leaving IDLE.
- start_pulse in any other state is ignored.
- gaming=1 in WAIT_TICK, MOVE, EVAL and SPAWN.

## Timing
- Reset values:
  - State IDLE; tick counter 0; retry_cnt 0.
  - All outputs 0, including score and retry_exhausted.
- Tick period (MOVE to MOVE) = DIV + 1 + EVAL wait + SPAWN wait cycles; the counter does not run outside WAIT_TICK.
- score updates on the clock edge after the eval_valid cycle.
- spawn_req rises the cycle after EVAL exits, and falls the cycle after ack.
- Re-request after a conflict is asserted 2 cycles after the ack cycle.
- rst mid-SPAWN: spawn_req is 0 in the cycle after the reset edge. No pending request survives reset.
- retry_exhausted is cleared only by rst or by a start_pulse restart.

## Configuration
- SCHED_PAUSE_EN defined:
  - pause_pulse in WAIT_TICK → PAUSED. The tick counter is frozen and gaming stays 1.
  - pause_pulse in PAUSED → WAIT_TICK, resuming the count.
  - pause_pulse in other states is ignored.
- SCHED_PAUSE_EN undefined: PAUSED is not built and pause_pulse is ignored. The port remains present.

## Structure
- Package snake_sched_pkg:
  - state enum.
  - SCORE_MAX=9999.
  - Apple increments APPLE_INC_SLOW=1 and APPLE_INC_FAST=2.
- Sub-module tick_divider: loadable down-counter with enable, load value, freeze and a terminal-count output.
- The FSM, score arithmetic and retry logic stay in the top of this block.

## Test plan
Bench parameters: SLOW_DIV=10, FAST_DIV=5, MAX_RETRY=3.
- Reset, then start_pulse, then eval_valid with no event each tick → move_stb every 12 cycles (10 count + MOVE + 1 EVAL wait). score=0, score_zero pulses once.
- speed=1 and three ate_apple evals, each followed by spawn_ack with conflict=0 → score=6; move period 7 cycles plus SPAWN latency.
- eval_valid with ate_apple=1, ate_drug=1, collide=1 → OVER. score unchanged, game_over=1, no spawn_req.
- Three consecutive conflicting acks → retry_exhausted=1, state WAIT_TICK; spawn_req pulsed three times.
- score=0 with ate_drug → score stays 0. Preload to 9998, slow mode, ate_apple twice → 9999.
- With SCHED_PAUSE_EN: pause at count 4 for 50 cycles, then resume → next move_stb 6 cycles after resume.
